// File: rtl/fpnew_norm_pipe_pkg.sv
// Shared types and helpers for the normalization pipe (fpnew_norm_pipe).
// The stage-1 register struct is sized for the package's default configuration.
package fpnew_norm_pipe_pkg;

  localparam int unsigned NormMantWidth = 48;
  localparam int unsigned NormPrecBits  = 24;
  localparam int unsigned NormExpBits   = 8;
  localparam int unsigned NormExpWidth  = 10;
  localparam int unsigned NormTagWidth  = 4;

  // Shift-amount width: must hold a saturated right shift of exactly MantWidth.
  function automatic int unsigned norm_shamt_w(input int unsigned mant_width);
    return $clog2(mant_width) + 1;
  endfunction

  localparam int unsigned NormShamtW = norm_shamt_w(NormMantWidth);

  typedef struct packed {
    logic [NormMantWidth-1:0]       mant;
    logic [NormShamtW-1:0]          shamt;
    logic                           shift_right;
    logic signed [NormExpWidth:0]   exp_f;
    logic                           zero;
    logic                           sign;
    logic                           eff_sub;
    logic [NormTagWidth-1:0]        tag;
  } norm_s1_t;

endpackage

// File: rtl/fpnew_norm_pipe_if.sv
// Handshake bundle for the normalization pipe: upstream operand side and
// downstream rounder side. master = producer/consumer around the pipe, slave = pipe.
interface fpnew_norm_pipe_if #(
  parameter int unsigned MantWidth = 48,
  parameter int unsigned PrecBits  = 24,
  parameter int unsigned ExpBits   = 8,
  parameter int unsigned ExpWidth  = 10,
  parameter int unsigned TagWidth  = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [MantWidth-1:0]          in_mant;
  logic signed [ExpWidth-1:0]    in_exp;
  logic                          in_sign;
  logic                          in_eff_sub;
  logic [TagWidth-1:0]           in_tag;
  logic                          out_valid;
  logic                          out_ready;
  logic [ExpBits+PrecBits-2:0]   abs_value;
  logic [1:0]                    round_sticky;
  logic                          out_sign;
  logic                          out_eff_sub;
  logic                          of;
  logic [TagWidth-1:0]           out_tag;

  modport master (
    output in_valid, in_mant, in_exp, in_sign, in_eff_sub, in_tag, out_ready,
    input  in_ready, out_valid, abs_value, round_sticky, out_sign, out_eff_sub, of, out_tag
  );

  modport slave (
    input  in_valid, in_mant, in_exp, in_sign, in_eff_sub, in_tag, out_ready,
    output in_ready, out_valid, abs_value, round_sticky, out_sign, out_eff_sub, of, out_tag
  );
endinterface

// File: rtl/fpnew_lzc.sv
// Parameterized zero counter. MODE=1 counts leading zeros (from MSB),
// MODE=0 counts trailing zeros. empty_o flags an all-zero input.
module fpnew_lzc #(
  parameter int unsigned WIDTH = 48,
  parameter bit          MODE  = 1'b1
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH)-1:0] cnt_o,
  output logic                     empty_o
);
  localparam int unsigned CntW = $clog2(WIDTH);

  // Priority scan; the first set bit in scan order fixes the count.
  always_comb begin
    cnt_o   = '0;
    empty_o = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (empty_o && in_i[MODE ? (WIDTH - 1 - i) : i]) begin
        cnt_o   = CntW'(i);
        empty_o = 1'b0;
      end
    end
  end
endmodule

// File: rtl/fpnew_norm_pipe.sv
// Two-stage normalization pipe feeding the FP rounder: stage 1 counts leading
// zeros and picks shift amount/direction and final exponent, stage 2 shifts and
// packs {exp, mant} with round/sticky. Optional macro FPNEW_NORM_STATS_EN adds
// saturating subnormal/overflow result counters.
module fpnew_norm_pipe
  import fpnew_norm_pipe_pkg::*;
#(
  parameter int unsigned MantWidth = NormMantWidth,
  parameter int unsigned PrecBits  = NormPrecBits,
  parameter int unsigned ExpBits   = NormExpBits,
  parameter int unsigned ExpWidth  = NormExpWidth,
  parameter int unsigned TagWidth  = NormTagWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  fpnew_norm_pipe_if.slave      pipe_io
`ifdef FPNEW_NORM_STATS_EN
  ,
  output logic [15:0]           stat_subnorm_o,
  output logic [15:0]           stat_of_o
`endif
);
  localparam int unsigned ShamtW  = norm_shamt_w(MantWidth);
  localparam int unsigned CntW    = $clog2(MantWidth);
  localparam int unsigned ExpExtW = ExpWidth + 1;
  localparam int unsigned AbsW    = ExpBits + PrecBits - 1;

  // The stage-1 struct comes from the package, so the widths must agree with it.
  if (MantWidth < PrecBits + 2 || MantWidth != NormMantWidth || ExpWidth != NormExpWidth ||
      TagWidth != NormTagWidth) begin : g_bad_cfg
    $error("fpnew_norm_pipe: unsupported parameter combination");
  end

  logic s1_valid_q, s2_valid_q, s1_ready, s2_ready;
  norm_s1_t s1_d, s1_q;
  logic [CntW-1:0] lzc_cnt;
  logic lzc_empty;
  logic signed [ExpExtW-1:0] exp_ext, lzc_ext, neg_exp;

  assign s2_ready = ~s2_valid_q | pipe_io.out_ready;
  assign s1_ready = ~s1_valid_q | s2_ready;
  assign pipe_io.in_ready  = s1_ready;
  assign pipe_io.out_valid = s2_valid_q;

  fpnew_lzc #(
    .WIDTH (MantWidth),
    .MODE  (1'b1)
  ) u_lzc (
    .in_i    (pipe_io.in_mant),
    .cnt_o   (lzc_cnt),
    .empty_o (lzc_empty)
  );

  // Stage 1: choose normal left shift, subnormal left shift, or saturated right shift.
  always_comb begin
    exp_ext = {pipe_io.in_exp[ExpWidth-1], pipe_io.in_exp};
    lzc_ext = ExpExtW'(lzc_cnt);
    neg_exp = -exp_ext;
    s1_d.mant        = pipe_io.in_mant;
    s1_d.zero        = lzc_empty;
    s1_d.sign        = pipe_io.in_sign;
    s1_d.eff_sub     = pipe_io.in_eff_sub;
    s1_d.tag         = pipe_io.in_tag;
    s1_d.shift_right = 1'b0;
    s1_d.shamt       = ShamtW'(lzc_cnt);
    s1_d.exp_f       = exp_ext - lzc_ext + ExpExtW'(1);
    if (lzc_ext > exp_ext) begin
      s1_d.exp_f = '0;
      if (!exp_ext[ExpExtW-1]) begin
        s1_d.shamt = ShamtW'(exp_ext);
      end else begin
        s1_d.shift_right = 1'b1;
        s1_d.shamt = (neg_exp > $signed(ExpExtW'(MantWidth))) ? ShamtW'(MantWidth)
                                                               : ShamtW'(neg_exp);
      end
    end
  end

  // Stage-1 data: loads whenever the stage can accept, valid or not.
  always_ff @(posedge clk_i) begin
    if (s1_ready) s1_q <= s1_d;
  end

  logic [2*MantWidth-1:0] wide;
  logic [MantWidth-1:0]   shifted;
  logic                   out_sticky, unused_hidden;
  logic [AbsW-1:0]        abs_d;
  logic [1:0]             rs_d;
  logic                   of_d, subnorm_d;

  // Stage 2: a double-width shift keeps right-shifted-out bits in the low half.
  always_comb begin
    wide = {s1_q.mant, {MantWidth{1'b0}}};
    if (s1_q.shift_right) wide = wide >> s1_q.shamt;
    else                  wide = wide << s1_q.shamt;
    shifted       = wide[2*MantWidth-1:MantWidth];
    out_sticky    = |wide[MantWidth-1:0];
    unused_hidden = shifted[MantWidth-1];
    of_d      = ~s1_q.zero && (s1_q.exp_f >= $signed(ExpExtW'(2**ExpBits - 1)));
    subnorm_d = ~s1_q.zero && (s1_q.exp_f == '0);
    abs_d = {s1_q.exp_f[ExpBits-1:0], shifted[MantWidth-2 -: PrecBits-1]};
    rs_d  = {shifted[MantWidth-PrecBits-1],
             (|shifted[MantWidth-PrecBits-2:0]) | out_sticky};
    if (s1_q.zero) begin
      abs_d = '0;
      rs_d  = 2'b00;
    end else if (of_d) begin
      abs_d = {ExpBits'(2**ExpBits - 2), {(PrecBits-1){1'b1}}};
      rs_d  = 2'b11;
    end
  end

  logic [AbsW-1:0]     abs_q;
  logic [1:0]          rs_q;
  logic                of_q, sign_q, eff_sub_q, subnorm_q;
  logic [TagWidth-1:0] tag_q;

  // Valid bits: flush and reset kill everything in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s1_ready) s1_valid_q <= pipe_io.in_valid;
      if (s2_ready) s2_valid_q <= s1_valid_q;
    end
  end

  // Output register: held while stalled, cleared on reset so outputs read zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      abs_q     <= '0;
      rs_q      <= '0;
      of_q      <= 1'b0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      subnorm_q <= 1'b0;
      tag_q     <= '0;
    end else if (s2_ready && s1_valid_q) begin
      abs_q     <= abs_d;
      rs_q      <= rs_d;
      of_q      <= of_d;
      sign_q    <= s1_q.sign;
      eff_sub_q <= s1_q.eff_sub;
      subnorm_q <= subnorm_d;
      tag_q     <= s1_q.tag;
    end
  end

  assign pipe_io.abs_value    = abs_q;
  assign pipe_io.round_sticky = rs_q;
  assign pipe_io.of           = of_q;
  assign pipe_io.out_sign     = sign_q;
  assign pipe_io.out_eff_sub  = eff_sub_q;
  assign pipe_io.out_tag      = tag_q;

`ifdef FPNEW_NORM_STATS_EN
  logic [15:0] stat_subnorm_q, stat_of_q;
  logic        out_hs;
  assign out_hs = s2_valid_q & pipe_io.out_ready;

  // Saturating result-class counters; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_subnorm_q <= '0;
      stat_of_q      <= '0;
    end else if (out_hs) begin
      if (subnorm_q && stat_subnorm_q != 16'hFFFF) stat_subnorm_q <= stat_subnorm_q + 16'd1;
      if (of_q && stat_of_q != 16'hFFFF)           stat_of_q      <= stat_of_q + 16'd1;
    end
  end

  assign stat_subnorm_o = stat_subnorm_q;
  assign stat_of_o      = stat_of_q;
`else
  logic unused_subnorm;
  assign unused_subnorm = subnorm_q;
`endif
endmodule

// File: tb/tb_fpnew_norm_pipe.sv
// Scoreboard bench for fpnew_norm_pipe: the driver pushes hand-computed
// expectations on each input handshake, a monitor pops on each output handshake.
module tb_fpnew_norm_pipe;
  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  fpnew_norm_pipe_if #(
    .MantWidth (48), .PrecBits (24), .ExpBits (8), .ExpWidth (10), .TagWidth (4)
  ) bus ();

`ifdef FPNEW_NORM_STATS_EN
  logic [15:0] stat_subnorm, stat_of;
`endif

  fpnew_norm_pipe dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .pipe_io (bus)
`ifdef FPNEW_NORM_STATS_EN
    ,
    .stat_subnorm_o (stat_subnorm),
    .stat_of_o      (stat_of)
`endif
  );

  typedef struct {
    logic [47:0]        mant;
    logic signed [9:0]  exp;
    logic [3:0]         tag;
    logic               sign;
    logic               eff_sub;
    logic [30:0]        abs_v;
    logic [1:0]         rs;
    logic               of;
  } vec_t;

  vec_t sb[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  function automatic vec_t mk(input logic [47:0] m, input int e, input logic [3:0] t,
                              input logic s, input logic es, input logic [30:0] a,
                              input logic [1:0] rs, input logic of);
    vec_t v;
    v.mant = m; v.exp = 10'(e); v.tag = t; v.sign = s; v.eff_sub = es;
    v.abs_v = a; v.rs = rs; v.of = of;
    return v;
  endfunction

  // Issue one op; wait (bounded) for in_ready and record its expectation.
  task automatic send(input vec_t v);
    bit hs = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_mant    = v.mant;
    bus.in_exp     = v.exp;
    bus.in_tag     = v.tag;
    bus.in_sign    = v.sign;
    bus.in_eff_sub = v.eff_sub;
    for (int c = 0; c < 50 && !hs; c++) begin
      @(negedge clk);
      hs = bus.in_ready;
      if (hs) sb.push_back(v);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!hs) check("send_timeout", 64'(hs), 64'd1);
  endtask

  // Monitor: pop and compare on each output handshake; check hold during stalls.
  bit          held = 1'b0;
  logic [30:0] held_abs;
  logic [3:0]  held_tag;
  initial begin
    vec_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (held) begin
          check("stall_hold_abs", 64'(bus.abs_value), 64'(held_abs));
          check("stall_hold_tag", 64'(bus.out_tag), 64'(held_tag));
        end
        if (bus.out_ready) begin
          held = 1'b0;
          if (sb.size() == 0) begin
            check("unexpected_output_tag", 64'(bus.out_tag), 64'hDEAD);
          end else begin
            e = sb.pop_front();
            check("out_abs", 64'(bus.abs_value), 64'(e.abs_v));
            check("out_rs", 64'(bus.round_sticky), 64'(e.rs));
            check("out_of", 64'(bus.of), 64'(e.of));
            check("out_tag", 64'(bus.out_tag), 64'(e.tag));
            check("out_sign", 64'(bus.out_sign), 64'(e.sign));
            check("out_eff_sub", 64'(bus.out_eff_sub), 64'(e.eff_sub));
          end
        end else begin
          held     = 1'b1;
          held_abs = bus.abs_value;
          held_tag = bus.out_tag;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t c1, s1;
  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_mant = '0; bus.in_exp = '0; bus.in_tag = '0;
    bus.in_sign = 1'b0; bus.in_eff_sub = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_in_ready", 64'(bus.in_ready), 64'd1);
    check("reset_abs", 64'(bus.abs_value), 64'd0);
    check("reset_rs_of_tag", {bus.round_sticky, bus.of, bus.out_tag}, 64'd0);
`ifdef FPNEW_NORM_STATS_EN
    check("reset_stats", {stat_subnorm, stat_of}, 64'd0);
`endif
    @(posedge clk); #1;

    // 1.0 normal: latency check on the first op.
    c1 = mk(48'h4000_0000_0000, 127, 4'd1, 1'b0, 1'b0, 31'h3F80_0000, 2'b00, 1'b0);
    send(c1);
    @(negedge clk);
    check("latency_cycle1_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("latency_cycle2_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;

    // Back-to-back directed vectors.
    send(mk(48'h8000_0080_0001, 126, 4'd2, 1'b1, 1'b0, 31'h3F80_0000, 2'b11, 1'b0));
    send(mk(48'h4000_0000_0000, -2, 4'd3, 1'b0, 1'b1, 31'h0010_0000, 2'b00, 1'b0));
    send(mk(48'h8000_0000_0000, 254, 4'd4, 1'b1, 1'b1, 31'h7F7F_FFFF, 2'b11, 1'b1));
    send(mk(48'h0, 100, 4'd5, 1'b0, 1'b0, 31'h0, 2'b00, 1'b0));
    send(mk(48'h0000_4000_0000, 3, 4'd6, 1'b0, 1'b0, 31'h0000_0200, 2'b00, 1'b0));
    send(mk(48'h4000_0000_0003, -3, 4'd7, 1'b1, 1'b0, 31'h0008_0000, 2'b01, 1'b0));
    repeat (4) @(posedge clk); #1;
    check("drain_directed", 64'(sb.size()), 64'd0);
`ifdef FPNEW_NORM_STATS_EN
    check("stat_subnorm", 64'(stat_subnorm), 64'd3);
    check("stat_of", 64'(stat_of), 64'd1);
`endif

    // Stall: tags 1,2,3 with out_ready low for 4 cycles.
    bus.out_ready = 1'b0;
    s1 = c1; s1.sign = 1'b1;
    s1.tag = 4'd1; send(s1);
    s1.tag = 4'd2; send(s1);
    @(negedge clk);
    check("stall_in_ready_low", 64'(bus.in_ready), 64'd0);
    fork
      begin
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
      begin
        s1.tag = 4'd3; send(s1);
      end
    join
    repeat (5) @(posedge clk); #1;
    check("drain_stall", 64'(sb.size()), 64'd0);

    // Flush with two ops in flight.
    bus.out_ready = 1'b0;
    s1.tag = 4'd8; send(s1);
    s1.tag = 4'd9; send(s1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;

    // Flush overrides a same-cycle input; in_ready stays high.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_mant = c1.mant; bus.in_exp = c1.exp; bus.in_tag = 4'd10;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_no_capture", 64'(bus.out_valid), 64'd0);
`ifdef FPNEW_NORM_STATS_EN
    check("stat_after_flush", {stat_subnorm, stat_of}, {48'd0, 16'd3, 16'd1});
`endif

    // Reset mid-stall.
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    s1.tag = 4'd12; send(s1);
    s1.tag = 4'd13; send(s1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_stall_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_stall_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef FPNEW_NORM_STATS_EN
    check("rst_stats", {stat_subnorm, stat_of}, 64'd0);
`endif
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk); #1;

    // Pipe still works after reset.
    s1.tag = 4'd14; send(s1);
    repeat (4) @(posedge clk); #1;
    check("drain_final", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
